aes_decipher_ctrl: RTL
======================

AES_DECIPHER_CTRL -- requirements
Module: aes_decipher_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named clk and reset.
REQ-002 Parameter INIT_ROUND, default 2'h0: round_type code for the initial AddRoundKey.
REQ-003 Parameter MAIN_ROUND, default 2'h1: round_type code for a full inverse round.
REQ-004 Parameter FINAL_ROUND, default 2'h2: round_type code for the last round (no InvMixColumns).
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 next  in  1  start request, single-cycle pulse or level, sampled only in IDLE.
REQ-008 keylen  in  2  00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10 = AES-256 (Nr=14), 11 = treated as 00.
REQ-009 ready  out  1  high when idle and the previous result is valid.
REQ-010 round_type  out  2  round selection to the datapath.
REQ-011 round_key_addr  out  4  round key index to the key memory.
REQ-012 sword_ctr  out  2  word index (0..3) fed to the shared inverse S-box.
REQ-013 sbox_we  out  1  write one substituted word, the word selected by sword_ctr.
REQ-014 block_we  out  1  write the full 128-bit round result.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, SBOX and UPDATE.
REQ-016 IDLE: ready=1, sbox_we=0, block_we=0.
- On next=1, latch Nr from keylen, load round_ctr=Nr-1, go to INIT.
- ready=0 from the following cycle.
REQ-017 INIT (exactly 1 cycle):
- round_type=INIT_ROUND, round_key_addr=Nr, block_we=1.
- Go to SBOX with sword_ctr=0.
REQ-018 SBOX (exactly 4 cycles):
- sbox_we=1, block_we=0.
- sword_ctr steps 0,1,2,3, one per cycle.
- round_key_addr=round_ctr, round_type=upcoming round type.
- After sword_ctr=3, go to UPDATE.
REQ-019 UPDATE (exactly 1 cycle):
- block_we=1, sbox_we=0, round_key_addr=round_ctr.
- round_type=MAIN_ROUND if round_ctr>0, else FINAL_ROUND.
REQ-020 UPDATE exit:
- If round_ctr=0, go to IDLE.
- Else decrement round_ctr, reset sword_ctr to 0, go to SBOX.
REQ-021 Latency, with cycle 0 = the edge that samples next:
- INIT in cycle 1, last UPDATE in cycle 1+5*Nr.
- ready=1 from cycle 2+5*Nr.
- Nr=10 gives 52, Nr=12 gives 62, Nr=14 gives 72.
REQ-022 next SHALL be ignored while ready=0; keylen changes during operation SHALL have no effect.
REQ-023 sword_ctr SHALL wrap 3->0 only on the SBOX-to-UPDATE transition, and SHALL hold 0 outside SBOX.
REQ-024 round_ctr SHALL never underflow: a decrement from 0 is unreachable.
REQ-025 next asserted in the same cycle that the FSM returns to IDLE SHALL be ignored; it is accepted from the first IDLE cycle onward.
REQ-026 In IDLE: round_type=INIT_ROUND, round_key_addr=0.
REQ-027 sbox_we and block_we SHALL never both be 1.

Reset
REQ-028 On reset assertion the outputs SHALL immediately take these values: ready=1, round_type=2'h0, round_key_addr=4'h0, sword_ctr=2'h0, sbox_we=0, block_we=0.
REQ-029 On reset assertion the FSM SHALL go to IDLE and round_ctr to 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no further write strobes.
REQ-031 After reset deassertion, the first rising edge with next=1 SHALL start a new operation.

Verification
REQ-032 keylen=00, next pulse:
- INIT with addr 10 in cycle 1.
- Addresses 9..1 as MAIN, then 0 as FINAL.
- 40 sbox_we and 11 block_we pulses.
- ready=1 at cycle 52.
REQ-033 keylen=10: INIT with addr 14, then addresses 13..0; ready=1 at cycle 72.
REQ-034 keylen=11: identical trace to keylen=00 (10 rounds).
REQ-035 next held high throughout:
- No restart while busy.
- The second operation starts on the first IDLE cycle, with INIT one cycle later.
REQ-036 keylen toggled during operation: round count is unchanged from the latched value.
REQ-037 Reset asserted in cycle 7 of a 10-round operation:
- ready=1 and both write strobes 0 immediately.
- A subsequent next runs a full 52-cycle operation.

Source files
------------

// File: rtl/aes_decipher_ctrl.sv
// Round sequencer for an AES inverse cipher datapath with a single shared inverse S-box.
// It runs one initial AddRoundKey, then Nr rounds of 4 S-box word writes plus 1 block write.
module aes_decipher_ctrl #(
    parameter logic [1:0] INIT_ROUND  = 2'h0,
    parameter logic [1:0] MAIN_ROUND  = 2'h1,
    parameter logic [1:0] FINAL_ROUND = 2'h2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next,
    input  logic [1:0] keylen,
    output logic       ready,
    output logic [1:0] round_type,
    output logic [3:0] round_key_addr,
    output logic [1:0] sword_ctr,
    output logic       sbox_we,
    output logic       block_we
);

    typedef enum logic [1:0] {IDLE, INIT, SBOX, UPDATE} state_t;

    state_t     state;
    logic [3:0] round_ctr;
    logic [3:0] nr;

    // keylen 11 is folded onto AES-128
    always_comb begin
        case (keylen)
            2'b01:   nr = 4'd12;
            2'b10:   nr = 4'd14;
            default: nr = 4'd10;
        endcase
    end

    function automatic logic [1:0] type_for(input logic [3:0] rc);
        return (rc != 4'd0) ? MAIN_ROUND : FINAL_ROUND;
    endfunction

    // All outputs are registered: each transition loads the values of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            round_ctr      <= 4'd0;
            ready          <= 1'b1;
            round_type     <= 2'h0;
            round_key_addr <= 4'h0;
            sword_ctr      <= 2'h0;
            sbox_we        <= 1'b0;
            block_we       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (next) begin
                        state          <= INIT;
                        round_ctr      <= nr - 4'd1;
                        ready          <= 1'b0;
                        round_type     <= INIT_ROUND;
                        round_key_addr <= nr;
                        block_we       <= 1'b1;
                    end
                end
                INIT: begin
                    state          <= SBOX;
                    sword_ctr      <= 2'd0;
                    sbox_we        <= 1'b1;
                    block_we       <= 1'b0;
                    round_key_addr <= round_ctr;
                    round_type     <= type_for(round_ctr);
                end
                SBOX: begin
                    sword_ctr <= sword_ctr + 2'd1;
                    if (sword_ctr == 2'd3) begin
                        state    <= UPDATE;
                        sbox_we  <= 1'b0;
                        block_we <= 1'b1;
                    end
                end
                UPDATE: begin
                    block_we <= 1'b0;
                    if (round_ctr == 4'd0) begin
                        state          <= IDLE;
                        ready          <= 1'b1;
                        round_type     <= INIT_ROUND;
                        round_key_addr <= 4'd0;
                    end else begin
                        state          <= SBOX;
                        round_ctr      <= round_ctr - 4'd1;
                        sword_ctr      <= 2'd0;
                        sbox_we        <= 1'b1;
                        round_key_addr <= round_ctr - 4'd1;
                        round_type     <= type_for(round_ctr - 4'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
